// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint rejection sampler.
//   state_e      : sampler FSM states
//   DEFAULT_TAPS : Fibonacci feedback mask x^10+x^7+1 for a 10-bit LFSR
//   TRIES_W      : width of the tries counter / tries_o port
package constraint_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2,
    FAIL   = 2'd3
  } state_e;

  localparam logic [9:0]  DEFAULT_TAPS = 10'h240;
  localparam int unsigned TRIES_W      = 16;

endpackage

// File: rtl/constraint_rejection_sampler_lfsr_step.sv
// Combinational next-state function of a Fibonacci LFSR.
//   cur_i : current LFSR value
//   nxt_o : {cur_i[W-2:0], parity(cur_i & TAPS)}
module lfsr_step
  import constraint_sampler_pkg::*;
#(
  parameter int unsigned     W    = 10,
  parameter logic [W-1:0]    TAPS = W'(DEFAULT_TAPS)
) (
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] nxt_o
);

  always_comb begin
    nxt_o = {cur_i[W-2:0], ^(cur_i & TAPS)};
  end

endmodule

// File: rtl/constraint_rejection_sampler.sv
// Rejection sampler: drives LFSR candidates to an external single-constraint
// checker, keeps the first accepted one and offers it on a valid/ready port.
// Gives up after MAX_TRIES rejected candidates.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : request one sample (honoured in IDLE or FAIL only)
//   cand_o          : current candidate (LFSR register) to the checker
//   cand_ok_i       : checker verdict for cand_o, same cycle
//   sample_o        : accepted candidate, meaningful while sample_valid_o
//   sample_valid_o  : sample available (HOLD state)
//   sample_ready_i  : downstream takes the sample
//   busy_o          : searching or holding a sample
//   fail_o          : try budget exhausted, sticky until next start/reset
//   tries_o         : candidates checked in the current or last request
module constraint_rejection_sampler
  import constraint_sampler_pkg::*;
#(
  parameter int unsigned  W         = 10,
  parameter logic [W-1:0] SEED      = W'(1),
  parameter int unsigned  MAX_TRIES = 1024,
  parameter logic [W-1:0] TAPS      = W'(DEFAULT_TAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [W-1:0]       cand_o,
  input  logic               cand_ok_i,
  output logic [W-1:0]       sample_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i,
  output logic               busy_o,
  output logic               fail_o,
  output logic [TRIES_W-1:0] tries_o
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [W-1:0]       SEED_EFF = (SEED == '0) ? W'(1) : SEED;
  localparam logic [TRIES_W-1:0] MAX_T    = TRIES_W'(MAX_TRIES);

  state_e               state_q, state_d;
  logic [W-1:0]         lfsr_q, lfsr_d, lfsr_nxt;
  logic [W-1:0]         sample_q, sample_d;
  logic [TRIES_W-1:0]   tries_q, tries_d, tries_inc;
  logic                 fail_q, fail_d;

  lfsr_step #(
    .W    (W),
    .TAPS (TAPS)
  ) u_lfsr_step (
    .cur_i (lfsr_q),
    .nxt_o (lfsr_nxt)
  );

  assign tries_inc = tries_q + TRIES_W'(1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    sample_d = sample_q;
    tries_d  = tries_q;
    fail_d   = fail_q;
    unique case (state_q)
      IDLE, FAIL: begin
        // The LFSR is deliberately not reseeded here so that back-to-back
        // requests continue the sequence.
        if (start_i) begin
          state_d = SEARCH;
          tries_d = '0;
          fail_d  = 1'b0;
        end
      end
      SEARCH: begin
        // Acceptance is tested first so a hit on the last allowed try wins.
        if (cand_ok_i) begin
          sample_d = lfsr_q;
          tries_d  = tries_inc;
          lfsr_d   = lfsr_nxt;
          state_d  = HOLD;
        end else if (tries_inc == MAX_T) begin
          tries_d = MAX_T;
          fail_d  = 1'b1;
          state_d = FAIL;
        end else begin
          tries_d = tries_inc;
          lfsr_d  = lfsr_nxt;
        end
      end
      HOLD: begin
        if (sample_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      sample_q <= '0;
      tries_q  <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
      tries_q  <= tries_d;
      fail_q   <= fail_d;
    end
  end

  assign cand_o         = lfsr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = (state_q == HOLD);
  assign busy_o         = (state_q == SEARCH) || (state_q == HOLD);
  assign fail_o         = fail_q;
  assign tries_o        = tries_q;

endmodule

// File: tb/tb_constraint_rejection_sampler.sv
// Directed bench for constraint_rejection_sampler. Three instances share
// clock and reset: A (default MAX_TRIES=1024), B (MAX_TRIES=8),
// C (MAX_TRIES=4).
module tb_constraint_rejection_sampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Instance A
  logic        start_a = 1'b0, ready_a = 1'b1, ok_force_a = 1'b1, use_chk_a = 1'b0;
  logic        ok_a, valid_a, busy_a, fail_a;
  logic [9:0]  cand_a, sample_a;
  logic [15:0] tries_a;
  assign ok_a = use_chk_a ? ~|cand_a[7:0] : ok_force_a;

  // Instance B: checker always rejects
  logic        start_b = 1'b0, ready_b = 1'b1;
  logic        ok_b, valid_b, busy_b, fail_b;
  logic [9:0]  cand_b, sample_b;
  logic [15:0] tries_b;
  assign ok_b = 1'b0;

  // Instance C: checker accepts only the 4th candidate from seed 1
  logic        start_c = 1'b0, ready_c = 1'b1;
  logic        ok_c, valid_c, busy_c, fail_c;
  logic [9:0]  cand_c, sample_c;
  logic [15:0] tries_c;
  assign ok_c = (cand_c == 10'h008);

  constraint_rejection_sampler dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .cand_o(cand_a),
    .cand_ok_i(ok_a), .sample_o(sample_a), .sample_valid_o(valid_a),
    .sample_ready_i(ready_a), .busy_o(busy_a), .fail_o(fail_a), .tries_o(tries_a)
  );

  constraint_rejection_sampler #(.MAX_TRIES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .cand_o(cand_b),
    .cand_ok_i(ok_b), .sample_o(sample_b), .sample_valid_o(valid_b),
    .sample_ready_i(ready_b), .busy_o(busy_b), .fail_o(fail_b), .tries_o(tries_b)
  );

  constraint_rejection_sampler #(.MAX_TRIES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .cand_o(cand_c),
    .cand_ok_i(ok_c), .sample_o(sample_c), .sample_valid_o(valid_c),
    .sample_ready_i(ready_c), .busy_o(busy_c), .fail_o(fail_c), .tries_o(tries_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] lfsr_nx(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  logic [9:0] seq_exp [12];
  logic [9:0] m, first_sample;
  int unsigned t;
  bit got;

  initial begin
    seq_exp[0] = 10'h001; seq_exp[1]  = 10'h002; seq_exp[2]  = 10'h004;
    seq_exp[3] = 10'h008; seq_exp[4]  = 10'h010; seq_exp[5]  = 10'h020;
    seq_exp[6] = 10'h040; seq_exp[7]  = 10'h081; seq_exp[8]  = 10'h102;
    seq_exp[9] = 10'h204; seq_exp[10] = 10'h009; seq_exp[11] = 10'h012;

    // Reset values
    tick(); tick();
    check("rst_cand", cand_a, 10'h001);
    check("rst_sample", sample_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fail", fail_a, 0);
    check("rst_tries", tries_a, 0);
    rst_n = 1'b1;
    tick();

    // Immediate accept (stub ok=1)
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t1_busy0", busy_a, 1);
    check("t1_valid0", valid_a, 0);
    check("t1_tries0", tries_a, 0);
    tick();
    check("t1_valid1", valid_a, 1);
    check("t1_sample", sample_a, 10'h001);
    check("t1_tries1", tries_a, 1);
    check("t1_busy1", busy_a, 1);
    check("t1_cand_adv", cand_a, 10'h002);
    tick();
    check("t1_valid2", valid_a, 0);
    check("t1_busy2", busy_a, 0);
    check("t1_tries_hold", tries_a, 1);

    // Hold with ready low, start during HOLD ignored
    ready_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", valid_a, 1);
      check("t4_sample", sample_a, 10'h002);
      check("t4_tries", tries_a, 1);
      start_a = (i == 2);
      tick();
    end
    start_a = 1'b0;
    check("t4_still_hold", valid_a, 1);
    ready_a = 1'b1;
    tick();
    check("t4_idle_valid", valid_a, 0);
    check("t4_idle_busy", busy_a, 0);
    tick();
    check("t4_no_queue", busy_a, 0);

    // Reset mid-SEARCH
    ok_force_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (37) tick();
    check("t5_tries37", tries_a, 37);
    check("t5_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cand", cand_a, 10'h001);
    check("t5_sample", sample_a, 0);
    check("t5_valid", valid_a, 0);
    check("t5_busy_rst", busy_a, 0);
    check("t5_fail", fail_a, 0);
    check("t5_tries", tries_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("t5_seq", cand_a, seq_exp[k]);
      tick();
    end

    // Real checker: low 8 bits zero
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    use_chk_a = 1'b1;
    ready_a = 1'b1;
    m = 10'h001; t = 0;
    for (int n = 0; n < 1100; n++) begin
      t++;
      if (m[7:0] == 8'h00) break;
      m = lfsr_nx(m);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      if (valid_a) begin got = 1'b1; break; end
      tick();
    end
    check("t2_valid", {31'd0, got}, 1);
    check("t2_in_set", {31'd0, (sample_a[7:0] == 8'h00) && (sample_a != 10'h000)}, 1);
    check("t2_sample", sample_a, m);
    check("t2_tries", tries_a, t);
    check("t2_fail", fail_a, 0);
    first_sample = sample_a;
    tick();
    m = lfsr_nx(m); t = 0;
    for (int n = 0; n < 1100; n++) begin
      t++;
      if (m[7:0] == 8'h00) break;
      m = lfsr_nx(m);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      if (valid_a) begin got = 1'b1; break; end
      tick();
    end
    check("t2b_valid", {31'd0, got}, 1);
    check("t2b_sample", sample_a, m);
    check("t2b_tries", tries_a, t);
    check("t2b_differs", {31'd0, sample_a != first_sample}, 1);
    check("t2b_fail", fail_a, 0);
    tick();

    // Budget exhaustion, MAX_TRIES=8
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("t3_busy", busy_b, 1);
    check("t3_tries0", tries_b, 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t3_nofail", fail_b, 0);
      check("t3_novalid", valid_b, 0);
      check("t3_tries", tries_b, k);
    end
    tick();
    check("t3_fail", fail_b, 1);
    check("t3_tries8", tries_b, 8);
    check("t3_busy_end", busy_b, 0);
    check("t3_valid_end", valid_b, 0);
    tick();
    check("t3_sticky", fail_b, 1);
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("t3_clr_fail", fail_b, 0);
    check("t3_clr_tries", tries_b, 0);
    check("t3_rebusy", busy_b, 1);

    // Accept on the last allowed try, MAX_TRIES=4
    start_c = 1'b1; tick(); start_c = 1'b0;
    tick(); tick(); tick();
    check("t6_cand4", cand_c, 10'h008);
    check("t6_tries3", tries_c, 3);
    tick();
    check("t6_valid", valid_c, 1);
    check("t6_tries4", tries_c, 4);
    check("t6_sample", sample_c, 10'h008);
    check("t6_nofail", fail_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
